// File: rtl/neopixel_frame_sequencer.sv
// neopixel_frame_sequencer
//
// Frame-level driver for a WS2812 chain. Keeps a NUM_PIXELS-entry GRB frame
// buffer and, on a start pulse, hands each pixel to the single-pixel
// serialiser in index order over a valid/busy handshake. After the last
// pixel it keeps the line idle for the WS2812 latch gap and then pulses
// frame_done.
//
// Ports:
//   CLK        system clock, all logic on the rising edge
//   RST        asynchronous active-high reset
//   start      one-cycle request to send the whole frame (honoured only in IDLE)
//   wr_en      frame-buffer write strobe
//   wr_addr    pixel index to write (indices >= NUM_PIXELS are dropped)
//   wr_data    colour as {G, R, B}
//   pix_valid  request to the serialiser; pix_g/r/b are valid while high
//   pix_g/r/b  colour bytes to the serialiser
//   pix_busy   busy from the serialiser
//   frame_busy high whenever the sequencer is not in IDLE
//   frame_done one-cycle pulse in the final latch-gap cycle
module neopixel_frame_sequencer #(
    parameter int unsigned NUM_PIXELS = 8,
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned LATCH_US   = 80,
    localparam int unsigned AW        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    output logic          pix_valid,
    output logic [7:0]    pix_g,
    output logic [7:0]    pix_r,
    output logic [7:0]    pix_b,
    input  logic          pix_busy,
    output logic          frame_busy,
    output logic          frame_done
);

    localparam int unsigned LATCH_CYCLES = (CLK_HZ / 1000000) * LATCH_US;
    localparam int unsigned CW           = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_PIXELS - 1);
    localparam logic [AW:0]   NUM_PIX    = (AW + 1)'(NUM_PIXELS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE,
        LATCH
    } state_t;

    state_t          state;
    logic [AW-1:0]   index;
    logic [CW-1:0]   latch_count;
    logic [23:0]     buffer [NUM_PIXELS];

    // Frame buffer. The extra leading zero lets the range check work even
    // when NUM_PIXELS is not a power of two. A write landing in the same
    // cycle as LOAD reads that entry is seen by the next frame, because the
    // sequencer samples the pre-edge contents.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_PIXELS); i++) begin
                buffer[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < NUM_PIX)) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // Sequencer. frame_done is raised on the edge that brings the latch
    // counter to its final value, so the pulse coincides with the last LATCH
    // cycle; a start in that cycle is therefore still ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            index       <= '0;
            latch_count <= '0;
            pix_valid   <= 1'b0;
            pix_g       <= '0;
            pix_r       <= '0;
            pix_b       <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        index      <= '0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    {pix_g, pix_r, pix_b} <= buffer[index];
                    pix_valid             <= 1'b1;
                    state                 <= SEND;
                end
                SEND: begin
                    // busy already high on entry counts as acceptance
                    if (pix_busy) begin
                        pix_valid <= 1'b0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!pix_busy) begin
                        if (index == LAST_IDX) begin
                            latch_count <= '0;
                            frame_done  <= (LATCH_LAST == '0);
                            state       <= LATCH;
                        end else begin
                            index <= index + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                LATCH: begin
                    if (latch_count == LATCH_LAST) begin
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        latch_count <= latch_count + 1'b1;
                        frame_done  <= ((latch_count + 1'b1) == LATCH_LAST);
                    end
                end
                default: begin
                    pix_valid  <= 1'b0;
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// tb_neopixel_frame_sequencer
//
// Bench for neopixel_frame_sequencer. Two instances: a 3-pixel chain at the
// default 960-cycle latch gap, driven by a behavioural serialiser model with
// a scoreboard, and a 1-pixel chain with a short latch gap, driven by hand.
module tb_neopixel_frame_sequencer;

    localparam int N3     = 3;
    localparam int LATCH3 = 960;

    logic clk;
    logic rst;

    // 3-pixel instance
    logic        start3, wr_en3, busy3, valid3, fbusy3, done3;
    logic [1:0]  wr_addr3;
    logic [23:0] wr_data3;
    logic [7:0]  g3, r3, b3;

    // 1-pixel instance, 12-cycle latch gap
    logic        start1, wr_en1, busy1, valid1, fbusy1, done1;
    logic [0:0]  wr_addr1;
    logic [23:0] wr_data1;
    logic [7:0]  g1, r1, b1;

    neopixel_frame_sequencer #(.NUM_PIXELS(3), .CLK_HZ(12000000), .LATCH_US(80)) dut3 (
        .CLK(clk), .RST(rst), .start(start3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .pix_valid(valid3), .pix_g(g3), .pix_r(r3), .pix_b(b3),
        .pix_busy(busy3), .frame_busy(fbusy3), .frame_done(done3)
    );

    neopixel_frame_sequencer #(.NUM_PIXELS(1), .CLK_HZ(12000000), .LATCH_US(1)) dut1 (
        .CLK(clk), .RST(rst), .start(start1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .pix_valid(valid1), .pix_g(g1), .pix_r(r1), .pix_b(b1),
        .pix_busy(busy1), .frame_busy(fbusy1), .frame_done(done1)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [23:0] data;
        logic [7:0]  exp_g;
        logic [7:0]  exp_r;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t        vecs [3];
    int          asserts  = 0;
    int          failures = 0;
    int          cycle    = 0;

    // Reference model: what the frame buffer holds, plus its contents during
    // the previous cycle (the value a pixel load in that cycle would see).
    logic [23:0] model_buf [N3] = '{default: 24'h0};
    logic [23:0] last_snap [N3] = '{default: 24'h0};
    logic [23:0] cap_q [$];
    int          hs_idx            = 0;
    int          done_count        = 0;
    int          fall_cycle        = 0;
    int          first_valid_cycle = 0;
    int          ser_delay         = 3;
    int          ser_hold          = 30;
    bit          rand_mode         = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 600000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [23:0] data);
        @(negedge clk);
        wr_en3   = 1'b1;
        wr_addr3 = addr;
        wr_data3 = data;
        @(negedge clk);
        wr_en3   = 1'b0;
    endtask

    task automatic startFrame(output int sc);
        @(negedge clk);
        start3 = 1'b1;
        sc     = cycle;
        @(negedge clk);
        start3 = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int dc = done_count;
        int n  = 0;
        while (done_count == dc && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_done_within_budget", 32'(done_count != dc), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkFrame(input string name, input logic [23:0] exp [3]);
        checkOutput({name, "_count"}, 32'(cap_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < cap_q.size()) checkOutput(name, 32'(cap_q[i]), 32'(exp[i]));
        end
    endtask

    // Buffer model: an in-range write takes effect at the clock edge; reset
    // clears everything.
    initial forever begin
        @(posedge clk);
        if (rst) model_buf = '{default: 24'h0};
        else if (wr_en3 && int'(wr_addr3) < N3) model_buf[wr_addr3] = wr_data3;
    end

    // Serialiser model with scoreboard. Accepts a pixel a programmable number
    // of cycles after valid, stays busy for a programmable time, and checks
    // every pixel against the buffer model and every frame for pixel count
    // and latch-gap length.
    initial begin
        int          phase = 0;
        int          left  = 0;
        logic [23:0] held  = '0;
        busy3 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase  = 0;
                busy3  = 1'b0;
                hs_idx = 0;
            end else begin
                if (done3) begin
                    done_count++;
                    checkOutput("pixels_per_frame", 32'(hs_idx), 32'(N3));
                    checkOutput("latch_gap", 32'(cycle - fall_cycle), 32'(LATCH3));
                    hs_idx = 0;
                end
                case (phase)
                    0: if (valid3) begin
                        held = {g3, r3, b3};
                        cap_q.push_back(held);
                        if (hs_idx == 0) first_valid_cycle = cycle;
                        checkOutput("pixel_in_range", 32'(hs_idx < N3), 32'd1);
                        if (hs_idx < N3) checkOutput("pixel_data", 32'(held), 32'(last_snap[hs_idx]));
                        left = rand_mode ? int'($urandom_range(0, 6)) : ser_delay;
                        if (left == 0) begin
                            busy3 = 1'b1;
                            left  = rand_mode ? int'($urandom_range(1, 8)) : ser_hold;
                            phase = 2;
                        end else begin
                            phase = 1;
                        end
                    end
                    1: begin
                        checkOutput("valid_held", 32'(valid3), 32'd1);
                        checkOutput("data_stable", 32'({g3, r3, b3}), 32'(held));
                        left--;
                        if (left == 0) begin
                            busy3 = 1'b1;
                            left  = rand_mode ? int'($urandom_range(1, 8)) : ser_hold;
                            phase = 2;
                        end
                    end
                    default: begin
                        left--;
                        if (left == 0) begin
                            busy3      = 1'b0;
                            fall_cycle = cycle;
                            hs_idx++;
                            phase      = 0;
                        end
                    end
                endcase
            end
            last_snap = model_buf;
        end
    end

    initial begin
        int          sc;
        int          dc0;
        int          rises;
        int          dones;
        int          n;
        bit          pv;
        bit          sent;
        logic [23:0] got;
        logic [23:0] exp_d [3];
        logic [23:0] zeros [3];

        rst = 1'b0;
        start3 = 1'b0; wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
        start1 = 1'b0; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; busy1 = 1'b0;
        #1 rst = 1'b1;

        vecs[0] = '{addr: 2'd0, data: 24'h00FF00, exp_g: 8'h00, exp_r: 8'hFF, exp_b: 8'h00};
        vecs[1] = '{addr: 2'd1, data: 24'h0000FF, exp_g: 8'h00, exp_r: 8'h00, exp_b: 8'hFF};
        vecs[2] = '{addr: 2'd2, data: 24'hFF0000, exp_g: 8'hFF, exp_r: 8'h00, exp_b: 8'h00};
        zeros   = '{24'h0, 24'h0, 24'h0};

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_pix_valid", 32'(valid3), 32'd0);
        checkOutput("reset_pix_grb", 32'({g3, r3, b3}), 32'd0);
        checkOutput("reset_frame_busy", 32'(fbusy3), 32'd0);
        checkOutput("reset_frame_done", 32'(done3), 32'd0);
        checkOutput("reset_single_busy", 32'(fbusy1), 32'd0);
        #2 rst = 1'b0;

        // Basic frame from a table of writes and expected handshakes
        $display("[TB] basic frame");
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i].addr, vecs[i].data);
        cap_q.delete();
        startFrame(sc);
        waitDone(3000);
        checkOutput("start_to_valid", 32'(first_valid_cycle - sc), 32'd2);
        checkOutput("basic_count", 32'(cap_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < cap_q.size()) begin
                got = cap_q[i];
                checkOutput("basic_g", 32'(got[23:16]), 32'(vecs[i].exp_g));
                checkOutput("basic_r", 32'(got[15:8]), 32'(vecs[i].exp_r));
                checkOutput("basic_b", 32'(got[7:0]), 32'(vecs[i].exp_b));
            end
        end

        // Starts in SEND, in LATCH and in the frame_done cycle are all dropped
        $display("[TB] ignored starts");
        dc0 = done_count; rises = 0; dones = 0; pv = 1'b0; sent = 1'b0;
        startFrame(sc);
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (valid3 && !pv) rises++;
            pv = valid3;
            if (done3) dones++;
            if (valid3 && !sent) begin
                start3 = 1'b1;
                sent   = 1'b1;
            end
            if (k == 500) start3 = 1'b1;
            if (done3) start3 = 1'b1;
        end
        start3 = 1'b0;
        checkOutput("ignored_start_pixels", 32'(rises), 32'd3);
        checkOutput("ignored_start_done_pulses", 32'(dones), 32'd1);
        checkOutput("ignored_start_done_count", 32'(done_count - dc0), 32'd1);

        // Long accept delay plus writes while pixel 0 waits in SEND
        $display("[TB] slow handshake and write during frame");
        ser_delay = 50;
        cap_q.delete();
        startFrame(sc);
        n = 0;
        while (!valid3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_send", 32'(valid3), 32'd1);
        applyStimulus(2'd2, 24'h123456);
        applyStimulus(2'd3, 24'hDEADBE);
        waitDone(4000);
        ser_delay = 3;
        exp_d = '{24'h00FF00, 24'h0000FF, 24'h123456};
        checkFrame("write_during_frame", exp_d);
        cap_q.delete();
        startFrame(sc);
        waitDone(3000);
        checkFrame("out_of_range_write_ignored", exp_d);

        // Reset while a pixel sits in SEND, then a frame of cleared pixels
        $display("[TB] reset mid-frame");
        ser_delay = 20;
        startFrame(sc);
        n = 0;
        while (!valid3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_reset_in_send", 32'(valid3), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_reset_pix_valid", 32'(valid3), 32'd0);
        checkOutput("mid_reset_frame_busy", 32'(fbusy3), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        ser_delay = 3;
        cap_q.delete();
        startFrame(sc);
        waitDone(3000);
        checkFrame("post_reset_zero_frame", zeros);

        // Single-pixel chain: one handshake, 12-cycle latch gap, done
        $display("[TB] single pixel");
        @(negedge clk);
        wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 24'hA1B2C3;
        @(negedge clk);
        wr_addr1 = 1'b1; wr_data1 = 24'hFFFFFF;
        @(negedge clk);
        wr_en1 = 1'b0;
        start1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) start1 = 1'b0;
            checkOutput("single_frame_busy", 32'(fbusy1), 32'(k >= 1 && k <= 15));
            checkOutput("single_frame_done", 32'(done1), 32'(k == 15));
            checkOutput("single_pix_valid", 32'(valid1), 32'(k == 2));
            if (k == 2) begin
                checkOutput("single_pix_grb", 32'({g1, r1, b1}), 32'h00A1B2C3);
                busy1 = 1'b1;
            end
            if (k == 3) busy1 = 1'b0;
        end

        // Randomised frames: random writes before and during each frame,
        // random serialiser timing and stray starts while busy
        $display("[TB] random frames");
        rand_mode = 1'b1;
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(1, 4)) applyStimulus(2'($urandom_range(0, 3)), 24'($urandom));
            dc0 = done_count;
            startFrame(sc);
            n = 0;
            while (done_count == dc0 && n < 4000) begin
                @(negedge clk);
                n++;
                wr_en3   = ($urandom_range(0, 3) == 0);
                wr_addr3 = 2'($urandom_range(0, 3));
                wr_data3 = 24'($urandom);
                start3   = fbusy3 && ($urandom_range(0, 7) == 0);
            end
            wr_en3 = 1'b0;
            start3 = 1'b0;
            checkOutput("random_frame_done", 32'(done_count - dc0), 32'd1);
            repeat (2) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
